// File: rtl/onehot_decoder_if.sv
// Handshake bundle between a select source and the one-hot decoder.
// The select side (master) drives mode, the select and the downstream ready;
// the decoder (slave) returns acceptance, the one-hot word and the error flag.
interface onehot_decoder_if #(
  parameter int OUT_W = 4
);
  localparam int IN_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic             mode;
  logic             in_vld;
  logic [IN_W-1:0]  in_sel;
  logic             in_rdy;
  logic [OUT_W-1:0] out;
  logic             out_vld;
  logic             out_rdy;
  logic             err;

  modport master (
    output mode, in_vld, in_sel, out_rdy,
    input  in_rdy, out, out_vld, err
  );

  modport slave (
    input  mode, in_vld, in_sel, out_rdy,
    output in_rdy, out, out_vld, err
  );
endinterface

// File: rtl/onehot_decoder.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides and a
// self-running scan mode that walks a single enable across all OUT_W lanes,
// dwelling STEP cycles on each. Selects >= OUT_W produce an all-zero word
// flagged by err instead of being dropped.
module onehot_decoder #(
  parameter int OUT_W = 4,
  parameter int STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  onehot_decoder_if.slave bus
);
  localparam int IN_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int CNT_W = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP - 1);
  localparam logic [IN_W-1:0]  IDX_LAST = IN_W'(OUT_W - 1);
  // One bit wider than the select so OUT_W itself is representable.
  localparam logic [IN_W:0]    SEL_LIM  = (IN_W + 1)'(OUT_W);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SCAN
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] out_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  idx;

  logic             sel_bad;
  logic [OUT_W-1:0] sel_hot;
  logic [IN_W-1:0]  idx_nxt;
  logic             cnt_last;

  // Decode of the incoming select; only ever captured into out_q, so in_sel
  // never reaches the outputs combinationally.
  assign sel_bad  = {1'b0, bus.in_sel} >= SEL_LIM;
  assign sel_hot  = sel_bad ? '0 : (OUT_W'(1) << bus.in_sel);

  assign idx_nxt  = (idx == IDX_LAST) ? '0 : idx + IN_W'(1);
  assign cnt_last = (cnt == CNT_LAST);

  // Acceptance depends only on state, mode and downstream ready.
  assign bus.in_rdy  = ~bus.mode & ((state == IDLE) | ((state == HOLD) & bus.out_rdy));
  // Valid is pure state decode: always in HOLD, at the end of a step in SCAN.
  assign bus.out_vld = (state == HOLD) | ((state == SCAN) & cnt_last);
  assign bus.out     = out_q;
  assign bus.err     = err_q;

  // Control FSM: decode/hold handshaking and the scan walk share out_q.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; mixing in = would make later lines see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_q <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.mode && bus.in_vld) begin
            out_q <= sel_hot;
            err_q <= sel_bad;
            state <= HOLD;
          end else if (bus.mode) begin
            idx   <= '0;
            cnt   <= '0;
            out_q <= OUT_W'(1);
            err_q <= 1'b0;
            state <= SCAN;
          end
        end

        HOLD: begin
          if (bus.out_rdy) begin
            if (!bus.mode && bus.in_vld) begin
              // Back-to-back: replace the drained result in the same cycle.
              out_q <= sel_hot;
              err_q <= sel_bad;
            end else begin
              // Drain to IDLE; a pending mode switch is taken from there.
              out_q <= '0;
              err_q <= 1'b0;
              state <= IDLE;
            end
          end
        end

        SCAN: begin
          if (!cnt_last) begin
            cnt <= cnt + CNT_W'(1);
          end else if (bus.out_rdy) begin
            // Mode is only sampled on a completed step transfer.
            if (bus.mode) begin
              cnt   <= '0;
              idx   <= idx_nxt;
              out_q <= OUT_W'(1) << idx_nxt;
            end else begin
              cnt   <= '0;
              idx   <= '0;
              out_q <= '0;
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          out_q <= '0;
          err_q <= 1'b0;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_onehot_decoder.sv
// Bench for onehot_decoder: instance A (OUT_W=4, STEP=4) and instance B
// (OUT_W=6, STEP=1) are checked against a behavioural model that tracks
// "holding a result" / "scanning position p for a cycles" directly.
module tb_onehot_decoder;
  logic clk;
  logic rst_n;

  int checks;
  int errors;

  onehot_decoder_if #(.OUT_W(4)) ia ();
  onehot_decoder_if #(.OUT_W(6)) ib ();

  onehot_decoder #(.OUT_W(4), .STEP(4)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  onehot_decoder #(.OUT_W(6), .STEP(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of one decoder.
  typedef struct {
    bit holding;
    bit scanning;
    int pos;
    int age;
    int val;
    bit e;
  } model_t;

  model_t ma;
  model_t mb;

  function automatic int exp_out(model_t m);
    if (m.scanning) return 1 << m.pos;
    if (m.holding)  return m.val;
    return 0;
  endfunction

  function automatic bit exp_vld(model_t m, int step);
    return m.holding || (m.scanning && m.age >= step - 1);
  endfunction

  function automatic bit exp_err(model_t m);
    return m.holding && m.e;
  endfunction

  function automatic bit exp_rdy(model_t m, bit mode, bit ordy);
    if (m.scanning) return 1'b0;
    if (m.holding)  return ordy && !mode;
    return !mode;
  endfunction

  function automatic model_t advance(model_t m, int ow, int step,
                                     bit mode, bit vld, int sel, bit ordy);
    model_t n;
    n = m;
    if (m.scanning) begin
      if (m.age >= step - 1 && ordy) begin
        if (mode) begin
          n.pos = (m.pos + 1) % ow;
          n.age = 0;
        end else begin
          n.scanning = 1'b0;
          n.pos = 0;
          n.age = 0;
        end
      end else if (m.age < step - 1) begin
        n.age = m.age + 1;
      end
    end else if (m.holding && !ordy) begin
      n = m;
    end else if (!mode && vld) begin
      n.holding = 1'b1;
      n.val = (sel < ow) ? (1 << sel) : 0;
      n.e = (sel >= ow);
    end else if (!m.holding && mode) begin
      n.scanning = 1'b1;
      n.pos = 0;
      n.age = 0;
    end else begin
      n.holding = 1'b0;
      n.val = 0;
      n.e = 1'b0;
    end
    return n;
  endfunction

  task automatic clear_models();
    ma = '{default: 0};
    mb = '{default: 0};
  endtask

  task automatic tick();
    if (rst_n) begin
      ma = advance(ma, 4, 4, ia.mode, ia.in_vld, int'(ia.in_sel), ia.out_rdy);
      mb = advance(mb, 6, 1, ib.mode, ib.in_vld, int'(ib.in_sel), ib.out_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    ia.mode = 1'b0; ia.in_vld = 1'b0; ia.in_sel = '0; ia.out_rdy = 1'b1;
    ib.mode = 1'b0; ib.in_vld = 1'b0; ib.in_sel = '0; ib.out_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    quiet_inputs();
    clear_models();
    #1;
    checks++;
    if (ia.out !== 4'b0000 || ia.out_vld !== 1'b0 || ia.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: out=%b vld=%b err=%b required 0000/0/0", ia.out, ia.out_vld, ia.err);
    end
    checks++;
    if (ib.out !== 6'b0 || ib.out_vld !== 1'b0 || ib.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: out=%b vld=%b err=%b required 0/0/0", ib.out, ib.out_vld, ib.err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ia.in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: in_rdy=%b required 1", ia.in_rdy);
    end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    ia.out_rdy = 1'b0; ia.in_vld = 1'b1; ia.in_sel = 2'd2;
    tick();
    ia.in_vld = 1'b0;
    checks++;
    if (ia.out !== 4'b0100 || ia.out_vld !== 1'b1) begin
      errors++;
      $display("FAIL hold_before_reset: out=%b vld=%b required 0100/1", ia.out, ia.out_vld);
    end
    #2;
    rst_n = 1'b0;
    clear_models();
    #1;
    checks++;
    if (ia.out !== 4'b0000 || ia.out_vld !== 1'b0 || ia.err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%b vld=%b err=%b required 0000/0/0", ia.out, ia.out_vld, ia.err);
    end
    #2;
    rst_n = 1'b1;
    ia.out_rdy = 1'b1;
    #1;
    checks++;
    if (ia.in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_after_reset: in_rdy=%b required 1", ia.in_rdy);
    end
    // First edge after release must accept.
    ia.in_vld = 1'b1; ia.in_sel = 2'd1;
    tick();
    ia.in_vld = 1'b0;
    checks++;
    if (ia.out !== 4'b0010 || ia.out_vld !== 1'b1) begin
      errors++;
      $display("FAIL first_accept: out=%b vld=%b required 0010/1", ia.out, ia.out_vld);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] tbl [4];
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ia.mode = 1'b0; ia.out_rdy = 1'b1;
    for (int s = 0; s < 4; s++) begin
      ia.in_vld = 1'b1; ia.in_sel = 2'(s);
      #1;
      checks++;
      if (ia.in_rdy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_rdy[%0d]: in_rdy=%b required 1", s, ia.in_rdy);
      end
      tick();
      checks++;
      if (ia.out !== tbl[s] || ia.out_vld !== 1'b1 || ia.err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_out[%0d]: out=%b vld=%b err=%b required %b/1/0", s, ia.out, ia.out_vld, ia.err, tbl[s]);
      end
    end
    ia.in_vld = 1'b0;
    tick();
    checks++;
    if (ia.out_vld !== 1'b0 || ia.out !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_drain: out=%b vld=%b required 0000/0", ia.out, ia.out_vld);
    end
  endtask

  task automatic test_backpressure();
    ia.mode = 1'b0; ia.out_rdy = 1'b1; ia.in_vld = 1'b1; ia.in_sel = 2'd2;
    tick();
    ia.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ia.in_rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_rdy[%0d]: in_rdy=%b required 0", i, ia.in_rdy);
      end
      tick();
      checks++;
      if (ia.out !== 4'b0100 || ia.out_vld !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out=%b vld=%b required 0100/1", i, ia.out, ia.out_vld);
      end
    end
    ia.out_rdy = 1'b1; ia.in_sel = 2'd3;
    #1;
    checks++;
    if (ia.in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_rdy: in_rdy=%b required 1", ia.in_rdy);
    end
    tick();
    checks++;
    if (ia.out !== 4'b1000) begin
      errors++;
      $display("FAIL bp_next: out=%b required 1000", ia.out);
    end
    ia.in_vld = 1'b0;
    tick();
  endtask

  task automatic test_range_error();
    logic [2:0] sels [3];
    logic [5:0] outs [3];
    logic       errs [3];
    sels = '{3'd6, 3'd7, 3'd5};
    outs = '{6'b000000, 6'b000000, 6'b100000};
    errs = '{1'b1, 1'b1, 1'b0};
    ib.mode = 1'b0; ib.out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ib.in_vld = 1'b1; ib.in_sel = sels[i];
      tick();
      checks++;
      if (ib.out !== outs[i] || ib.out_vld !== 1'b1 || ib.err !== errs[i]) begin
        errors++;
        $display("FAIL range[%0d]: out=%b vld=%b err=%b required %b/1/%b", i, ib.out, ib.out_vld, ib.err, outs[i], errs[i]);
      end
    end
    ib.in_vld = 1'b0;
    tick();
  endtask

  task automatic test_scan_wrap();
    int n;
    ia.mode = 1'b1; ia.out_rdy = 1'b1; ia.in_vld = 1'b1; ia.in_sel = 2'd3;
    tick();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (ia.out !== 4'(1 << ((i / 4) % 4)) || ia.out_vld !== ((i % 4) == 3) || ia.err !== 1'b0) begin
        errors++;
        $display("FAIL scan_a[%0d]: out=%b vld=%b err=%b required %b/%b/0", i, ia.out, ia.out_vld, ia.err, 4'(1 << ((i / 4) % 4)), (i % 4) == 3);
      end
      tick();
    end
    ia.mode = 1'b0; ia.in_vld = 1'b0;
    n = 0;
    while (ma.scanning && n < 16) begin
      tick();
      n++;
    end
    checks++;
    if (ia.out !== 4'b0000 || ia.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL scan_a_exit: out=%b vld=%b required 0000/0", ia.out, ia.out_vld);
    end
    // STEP = 1: one position per cycle.
    ib.mode = 1'b1; ib.out_rdy = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (ib.out !== 6'(1 << (i % 6)) || ib.out_vld !== 1'b1) begin
        errors++;
        $display("FAIL scan_b[%0d]: out=%b vld=%b required %b/1", i, ib.out, ib.out_vld, 6'(1 << (i % 6)));
      end
      tick();
    end
    ib.mode = 1'b0;
    tick();
    checks++;
    if (ib.out !== 6'b0 || ib.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL scan_b_exit: out=%b vld=%b required 0/0", ib.out, ib.out_vld);
    end
  endtask

  task automatic test_mode_change();
    ia.mode = 1'b1; ia.out_rdy = 1'b1; ia.in_vld = 1'b0;
    tick();            // enter scan, step count 0
    tick();            // step count 1
    ia.mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ia.out !== 4'b0001 || ia.out_vld !== (i == 2)) begin
        errors++;
        $display("FAIL mc_continue[%0d]: out=%b vld=%b required 0001/%b", i, ia.out, ia.out_vld, i == 2);
      end
      tick();
    end
    checks++;
    if (ia.out !== 4'b0000 || ia.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL mc_idle: out=%b vld=%b required 0000/0", ia.out, ia.out_vld);
    end
    // Stall at the end of a step: output frozen while out_rdy is low.
    ia.mode = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ia.out_rdy = 1'b0; ia.mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ia.out !== 4'b0001 || ia.out_vld !== 1'b1) begin
        errors++;
        $display("FAIL mc_stall[%0d]: out=%b vld=%b required 0001/1", i, ia.out, ia.out_vld);
      end
      tick();
    end
    ia.out_rdy = 1'b1;
    tick();
    checks++;
    if (ia.out !== 4'b0000 || ia.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL mc_stall_exit: out=%b vld=%b required 0000/0", ia.out, ia.out_vld);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) ia.mode = ~ia.mode;
      if ($urandom_range(0, 9) == 0) ib.mode = ~ib.mode;
      ia.in_vld = 1'($urandom_range(0, 1));
      ib.in_vld = 1'($urandom_range(0, 1));
      ia.in_sel = 2'($urandom_range(0, 3));
      ib.in_sel = 3'($urandom_range(0, 7));
      ia.out_rdy = ($urandom_range(0, 3) != 0);
      ib.out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (ia.out !== 4'(exp_out(ma)) || ia.out_vld !== exp_vld(ma, 4) || ia.err !== exp_err(ma)
          || ia.in_rdy !== exp_rdy(ma, ia.mode, ia.out_rdy) || $countones(ia.out) > 1) begin
        errors++;
        $display("FAIL rand_a[%0d]: out=%b vld=%b err=%b rdy=%b required %b/%b/%b/%b", c, ia.out, ia.out_vld, ia.err, ia.in_rdy,
                 4'(exp_out(ma)), exp_vld(ma, 4), exp_err(ma), exp_rdy(ma, ia.mode, ia.out_rdy));
      end
      checks++;
      if (ib.out !== 6'(exp_out(mb)) || ib.out_vld !== exp_vld(mb, 1) || ib.err !== exp_err(mb)
          || ib.in_rdy !== exp_rdy(mb, ib.mode, ib.out_rdy) || $countones(ib.out) > 1) begin
        errors++;
        $display("FAIL rand_b[%0d]: out=%b vld=%b err=%b rdy=%b required %b/%b/%b/%b", c, ib.out, ib.out_vld, ib.err, ib.in_rdy,
                 6'(exp_out(mb)), exp_vld(mb, 1), exp_err(mb), exp_rdy(mb, ib.mode, ib.out_rdy));
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid_hold();
    test_back_to_back();
    test_backpressure();
    test_range_error();
    test_scan_wrap();
    test_mode_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
